// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: any depth >= 2, fill count, almost flags, flush, registered or FWFT read.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_param #(
    parameter int DEPTH         = 32,
    parameter int WIDTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       wr_en_i,
    output logic                       full_o,
    output logic                       almost_full_o,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       rvalid_o,
    output logic                       empty_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             wr_accept, rd_accept;

    // Every status flag is a pure decode of the registered occupancy.
    assign count_o        = count_reg;
    assign full_o         = (count_reg == FULL_C);
    assign empty_o        = (count_reg == '0);
    assign almost_full_o  = (count_reg >= AFULL_C);
    assign almost_empty_o = (count_reg <= AEMPTY_C);

    always_comb begin
        wr_accept   = wr_en_i && !full_o && !flush_i;
        rd_accept   = rd_en_i && !empty_o && !flush_i;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_accept)
                wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
            if (rd_accept)
                rd_ptr_next = (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
            case ({wr_accept, rd_accept})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_accept)
            mem[wr_ptr_reg] <= wdata_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft_read
            // Head word is forced to zero while empty so reset shows rdata_o = 0.
            assign rdata_o  = empty_o ? '0 : mem[rd_ptr_reg];
            assign rvalid_o = !empty_o;
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata_reg;
            logic             rvalid_reg;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_accept;
                    if (rd_accept)
                        rdata_reg <= mem[rd_ptr_reg];
                end
            end
            assign rdata_o  = rdata_reg;
            assign rvalid_o = rvalid_reg;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_reg, underflow_reg;
    // Sticky until reset; flush neither sets nor clears them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en_i && full_o && !flush_i)
                overflow_reg <= 1'b1;
            if (rd_en_i && empty_o && !flush_i)
                underflow_reg <= 1'b1;
        end
    end
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule
